fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the single-cycle core's decode/control path. Owns the fetch PC, issues in-order 32-bit instruction requests to instruction memory over a valid/ready bus, buffers returned words with their PCs in a DEPTH-entry prefetch queue, and presents one instruction per cycle to the core. Branch redirects from the core flush the queue, discard in-flight responses and restart fetch at the new PC.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order requests to imem,
// buffers returned words with their PCs in a prefetch queue, and flushes on redirect.
module fetch_unit #(
    parameter int          DEPTH  = 4,
    parameter logic [63:0] INITPC = 64'h0000000000000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        halt,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        inst_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {FETCH, DRAIN, STOPPED} state_t;
    state_t state, state_n;

    logic [63:0]   fetch_pc, rsp_pc, target;
    logic [CW-1:0] outstanding, out_n, drop, drop_n, count;
    logic [AW-1:0] head, tail;
    logic [31:0]   q_data [DEPTH];
    logic [63:0]   q_pc   [DEPTH];
    logic          req_hs, push, pop;
    logic [CW:0]   credit_used;

    assign target      = redirect_pc & ~64'h3;
    // Credit covers both in-flight and queued words, so a response can never overflow the queue.
    assign credit_used = {1'b0, outstanding} + {1'b0, count};

    assign imem_req_valid = reset && !halt && (credit_used < {1'b0, FULL});
    assign imem_req_addr  = fetch_pc;
    assign inst_valid     = (count != '0);
    assign inst           = q_data[head];
    assign inst_pc        = q_pc[head];

    always_comb begin
        req_hs  = imem_req_valid && imem_req_ready;
        push    = imem_rsp_valid && (drop == '0) && !redirect;
        pop     = inst_valid && inst_ready && !redirect;
        out_n   = outstanding;
        drop_n  = drop;
        state_n = state;
        if (req_hs && !imem_rsp_valid)
            out_n = outstanding + CW'(1);
        else if (!req_hs && imem_rsp_valid)
            out_n = outstanding - CW'(1);
        // Everything still in flight after this cycle belongs to the old path.
        if (redirect)
            drop_n = out_n;
        else if (imem_rsp_valid && drop != '0)
            drop_n = drop - CW'(1);
        if (halt && out_n == '0)
            state_n = STOPPED;
        else if (drop_n != '0)
            state_n = DRAIN;
        else
            state_n = FETCH;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            fetch_pc    <= INITPC;
            rsp_pc      <= INITPC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else begin
            state       <= state_n;
            outstanding <= out_n;
            drop        <= drop_n;
            if (redirect) begin
                fetch_pc <= target;
                rsp_pc   <= target;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (req_hs)
                    fetch_pc <= fetch_pc + 64'd4;
                if (push) begin
                    q_data[tail] <= imem_rsp_data;
                    q_pc[tail]   <= rsp_pc;
                    tail         <= tail + AW'(1);
                    rsp_pc       <= rsp_pc + 64'd4;
                end
                if (pop)
                    head <= head + AW'(1);
                if (push && !pop)
                    count <= count + CW'(1);
                else if (pop && !push)
                    count <= count - CW'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && count == FULL));
    a_drain_state: assert property (@(posedge clk) disable iff (!reset)
        (state == DRAIN) == (drop != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus hand sequences for redirect and reset corners.
module tb_fetch_unit;
    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;

    fetch_unit #(.DEPTH(4), .INITPC(64'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          ir;
        bit          hlt;
        bit          rd;
        logic [63:0] rd_pc;
        bit          rv;
        logic [63:0] addr;
        bit          iv;
        logic [63:0] pc;
        logic [31:0] ins;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    pend_t pend[$];
    vec_t  tbl[$];
    int    cyc = 0;
    int    lat = 1;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit rdy, input bit ir, input bit hlt, input bit rd, input logic [63:0] rdpc);
        imem_req_ready = rdy;
        inst_ready     = ir;
        halt           = hlt;
        redirect       = rd;
        redirect_pc    = rdpc;
    endtask

    // Memory model: response data is addr>>2, arriving lat edges after the request edge.
    task automatic step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pend.size() != 0 && pend[0].due == cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend[0].addr[33:2];
            void'(pend.pop_front());
        end
        if (imem_req_valid && imem_req_ready)
            pend.push_back('{imem_req_addr, cyc + 1 + lat});
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_valid"}, {63'h0, imem_req_valid}, 64'h0);
        chk({tag, " req_addr"}, imem_req_addr, 64'h0);
        chk({tag, " inst_valid"}, {63'h0, inst_valid}, 64'h0);
        chk({tag, " inst"}, {32'h0, inst}, 64'h0);
        chk({tag, " inst_pc"}, inst_pc, 64'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        pend.delete();
        #1;
        chk_reset_outputs("reset");
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic vec_t mk(bit rst, bit rdy, bit ir, bit hlt, bit rd, logic [63:0] rd_pc,
                                bit rv, logic [63:0] addr, bit iv, logic [63:0] pc, logic [31:0] ins);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.ir = ir; v.hlt = hlt; v.rd = rd; v.rd_pc = rd_pc;
        v.rv = rv; v.addr = addr; v.iv = iv; v.pc = pc; v.ins = ins;
        return v;
    endfunction

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        // streaming, 1-cycle memory
        tbl.push_back(mk(1, 1, 1, 0, 0, 64'h0, 1, 64'h00, 0, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'h04, 0, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'h08, 1, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'h0c, 1, 64'h4, 32'h1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'h10, 1, 64'h8, 32'h2));
        // core stalled: queue fills to DEPTH, then drains and fetch resumes at 0x10
        tbl.push_back(mk(1, 1, 0, 0, 0, 64'h0, 1, 64'h00, 0, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 64'h0, 1, 64'h04, 0, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 64'h0, 1, 64'h08, 1, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 64'h0, 1, 64'h0c, 1, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 64'h0, 0, 64'h10, 1, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 64'h0, 0, 64'h10, 1, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 64'h0, 0, 64'h10, 1, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 0, 64'h10, 1, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'h10, 1, 64'h4, 32'h1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'h14, 1, 64'h8, 32'h2));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'h18, 1, 64'hc, 32'h3));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'h1c, 1, 64'h10, 32'h4));
        // halt mid-stream: queued words still delivered, resume at next sequential PC
        tbl.push_back(mk(1, 1, 1, 0, 0, 64'h0, 1, 64'h00, 0, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'h04, 0, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'h08, 1, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 64'h0, 0, 64'h0c, 1, 64'h4, 32'h1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 64'h0, 0, 64'h0c, 1, 64'h8, 32'h2));
        tbl.push_back(mk(0, 1, 1, 1, 0, 64'h0, 0, 64'h0c, 0, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'h0c, 0, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'h10, 0, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'h14, 1, 64'hc, 32'h3));
        // redirect to top of address space (dropping the request accepted that cycle), then wrap
        tbl.push_back(mk(1, 1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h0, 0, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'h0, 0, 64'h0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'h4, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF));
        tbl.push_back(mk(0, 1, 1, 0, 0, 64'h0, 1, 64'h8, 1, 64'h0, 32'h0));

        #2;
        lat = 1;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i].rdy, tbl[i].ir, tbl[i].hlt, tbl[i].rd, tbl[i].rd_pc);
            #1;
            chk($sformatf("row%0d req_valid", i), {63'h0, imem_req_valid}, {63'h0, tbl[i].rv});
            chk($sformatf("row%0d req_addr", i), imem_req_addr, tbl[i].addr);
            chk($sformatf("row%0d inst_valid", i), {63'h0, inst_valid}, {63'h0, tbl[i].iv});
            if (tbl[i].iv) begin
                chk($sformatf("row%0d inst_pc", i), inst_pc, tbl[i].pc);
                chk($sformatf("row%0d inst", i), {32'h0, inst}, {32'h0, tbl[i].ins});
            end
            step();
        end

        // 3-cycle memory, redirect to 0x103 with two requests in flight
        lat = 3;
        do_reset();
        drive(1, 1, 0, 0, 64'h0); #1; step();
        drive(1, 1, 0, 0, 64'h0); #1; step();
        drive(0, 1, 0, 1, 64'h103); #1; step();
        drive(1, 1, 0, 0, 64'h0); #1;
        chk("lat3 redirect req_addr", imem_req_addr, 64'h100);
        chk("lat3 redirect req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("lat3 redirect inst_valid", {63'h0, inst_valid}, 64'h0);
        step();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("lat3 stale%0d inst_valid", k), {63'h0, inst_valid}, 64'h0);
            step();
        end
        #1;
        chk("lat3 first inst_valid", {63'h0, inst_valid}, 64'h1);
        chk("lat3 first inst_pc", inst_pc, 64'h100);
        chk("lat3 first inst", {32'h0, inst}, 64'h40);
        step();
        #1;
        chk("lat3 second inst_pc", inst_pc, 64'h104);
        chk("lat3 second inst", {32'h0, inst}, 64'h41);
        step();

        // redirect coinciding with a request handshake and a response
        lat = 1;
        do_reset();
        drive(1, 1, 0, 0, 64'h0); #1; step();
        drive(1, 1, 0, 0, 64'h0); #1; step();
        drive(1, 1, 0, 1, 64'h200); #1;
        chk("coinc pre inst_pc", inst_pc, 64'h0);
        chk("coinc pre req_valid", {63'h0, imem_req_valid}, 64'h1);
        step();
        drive(1, 1, 0, 0, 64'h0); #1;
        chk("coinc c1 inst_valid", {63'h0, inst_valid}, 64'h0);
        chk("coinc c1 req_addr", imem_req_addr, 64'h200);
        step();
        #1;
        chk("coinc c2 inst_valid", {63'h0, inst_valid}, 64'h0);
        chk("coinc c2 req_addr", imem_req_addr, 64'h204);
        step();
        #1;
        chk("coinc c3 inst_valid", {63'h0, inst_valid}, 64'h1);
        chk("coinc c3 inst_pc", inst_pc, 64'h200);
        chk("coinc c3 inst", {32'h0, inst}, 64'h80);
        step();
        #1;
        chk("coinc c4 inst_pc", inst_pc, 64'h204);
        chk("coinc c4 inst", {32'h0, inst}, 64'h81);
        step();

        // reset asserted mid-burst takes effect without a clock edge
        #1;
        chk("burst inst_valid", {63'h0, inst_valid}, 64'h1);
        reset = 1'b0;
        pend.delete();
        imem_rsp_valid = 1'b0;
        #1;
        chk_reset_outputs("midreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
